// File: rtl/mem_wb_arbiter.sv
// mem_wb_arbiter: round-robin share of the memory-side PRF/ROB writeback port among LSU, complex unit and CSR
module mem_wb_arbiter #(
  parameter int DW   = 32,
  parameter int ROBW = 6,
  parameter int PRFW = 6
) (
  input  logic              cpu_clk_i,
  input  logic              cpu_rst_ni,
  input  logic              flush_i,
  input  logic [2:0]        src_vld_i,
  output logic [2:0]        src_rdy_o,
  input  logic [3*DW-1:0]   src_data_i,
  input  logic [3*PRFW-1:0] src_dest_i,
  input  logic [3*ROBW-1:0] src_rob_i,
  input  logic [2:0]        src_excp_i,
  input  logic [11:0]       src_code_i,
  output logic              p2_we_o,
  output logic [DW-1:0]     p2_we_data_o,
  output logic [PRFW-1:0]   p2_we_dest_o,
  output logic              completion_valid_o,
  output logic [ROBW-1:0]   completed_rob_o,
  output logic              exception_o,
  output logic [3:0]        exception_code_o,
  output logic [15:0]       conflict_cnt_o
);
  logic [2:0]      slot_vld, slot_excp, grant, acc;
  logic [DW-1:0]   slot_data [3];
  logic [PRFW-1:0] slot_dest [3];
  logic [ROBW-1:0] slot_rob [3];
  logic [3:0]      slot_code [3];
  logic [1:0]      rr_ptr, nxt1, nxt2, gnt_idx;
  logic            gnt_any, conflict;
  logic            wb_vld, wb_excp;
  logic [DW-1:0]   wb_data;
  logic [PRFW-1:0] wb_dest;
  logic [ROBW-1:0] wb_rob;
  logic [3:0]      wb_code;
  always_comb begin
    nxt1      = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
    nxt2      = (rr_ptr == 2'd0) ? 2'd2 : rr_ptr - 2'd1;
    gnt_any   = |slot_vld;
    gnt_idx   = slot_vld[rr_ptr] ? rr_ptr : slot_vld[nxt1] ? nxt1 : nxt2;
    grant     = gnt_any ? (3'b001 << gnt_idx) : 3'b000;
    src_rdy_o = {3{!flush_i}} & (~slot_vld | grant);
    acc       = src_vld_i & src_rdy_o;
    conflict  = (slot_vld[0] & slot_vld[1]) | (slot_vld[0] & slot_vld[2]) | (slot_vld[1] & slot_vld[2]);
  end
  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      slot_vld       <= 3'b000;
      slot_excp      <= 3'b000;
      rr_ptr         <= 2'd0;
      wb_vld         <= 1'b0;
      wb_excp        <= 1'b0;
      wb_data        <= '0;
      wb_dest        <= '0;
      wb_rob         <= '0;
      wb_code        <= '0;
      conflict_cnt_o <= '0;
      for (int i = 0; i < 3; i++) begin
        slot_data[i] <= '0;
        slot_dest[i] <= '0;
        slot_rob[i]  <= '0;
        slot_code[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) begin
          slot_data[i] <= src_data_i[i*DW +: DW];
          slot_dest[i] <= src_dest_i[i*PRFW +: PRFW];
          slot_rob[i]  <= src_rob_i[i*ROBW +: ROBW];
          slot_code[i] <= src_code_i[i*4 +: 4];
          slot_excp[i] <= src_excp_i[i];
        end
      end
      if (flush_i) begin
        slot_vld <= 3'b000;
        wb_vld   <= 1'b0;
        rr_ptr   <= 2'd0;
      end else begin
        // a refill of the granted slot wins over its drain
        slot_vld <= (slot_vld & ~grant) | acc;
        wb_vld   <= gnt_any;
        if (gnt_any) begin
          wb_data <= slot_data[gnt_idx];
          wb_dest <= slot_dest[gnt_idx];
          wb_rob  <= slot_rob[gnt_idx];
          wb_code <= slot_code[gnt_idx];
          wb_excp <= slot_excp[gnt_idx];
          rr_ptr  <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
        end
        if (conflict && conflict_cnt_o != 16'hFFFF) conflict_cnt_o <= conflict_cnt_o + 16'd1;
      end
    end
  end
  assign p2_we_o            = wb_vld & !wb_excp & (wb_dest != '0);
  assign completion_valid_o = wb_vld & !wb_excp;
  assign exception_o        = wb_vld & wb_excp;
  assign exception_code_o   = wb_code;
  assign completed_rob_o    = wb_rob;
  assign p2_we_data_o       = wb_data;
  assign p2_we_dest_o       = wb_dest;
endmodule

// File: tb/tb_mem_wb_arbiter.sv
// tb_mem_wb_arbiter: scenario tasks plus a writeback scoreboard for mem_wb_arbiter
module tb_mem_wb_arbiter;
  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  dest;
    logic [5:0]  rob;
    logic        excp;
    logic [3:0]  code;
  } exp_t;
  logic        cpu_clk_i, cpu_rst_ni, flush_i;
  logic [2:0]  src_vld, src_rdy, src_excp;
  logic [95:0] src_data;
  logic [17:0] src_dest, src_rob;
  logic [11:0] src_code;
  logic        p2_we_o, completion_valid_o, exception_o;
  logic [31:0] p2_we_data_o;
  logic [5:0]  p2_we_dest_o, completed_rob_o;
  logic [3:0]  exception_code_o;
  logic [15:0] conflict_cnt_o;
  exp_t        sb[$];
  exp_t        e;
  int          n_cmp, n_err, exp_conf;
  bit          mon_en;

  mem_wb_arbiter dut (
    .cpu_clk_i(cpu_clk_i), .cpu_rst_ni(cpu_rst_ni), .flush_i(flush_i),
    .src_vld_i(src_vld), .src_rdy_o(src_rdy), .src_data_i(src_data),
    .src_dest_i(src_dest), .src_rob_i(src_rob), .src_excp_i(src_excp),
    .src_code_i(src_code), .p2_we_o(p2_we_o), .p2_we_data_o(p2_we_data_o),
    .p2_we_dest_o(p2_we_dest_o), .completion_valid_o(completion_valid_o),
    .completed_rob_o(completed_rob_o), .exception_o(exception_o),
    .exception_code_o(exception_code_o), .conflict_cnt_o(conflict_cnt_o)
  );

  initial cpu_clk_i = 1'b0;
  always #5 cpu_clk_i = ~cpu_clk_i;

  // scoreboard: every writeback strobe must match the oldest expected entry
  always @(negedge cpu_clk_i) begin
    if (mon_en && cpu_rst_ni && (p2_we_o || completion_valid_o || exception_o)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got rob=%h data=%h, required no writeback", completed_rob_o, p2_we_data_o);
      end else begin
        e = sb.pop_front();
        if ({p2_we_o, completion_valid_o, exception_o, completed_rob_o, exception_code_o, p2_we_data_o, p2_we_dest_o}
            !== {!e.excp && e.dest != 6'd0, !e.excp, e.excp, e.rob, e.code, e.data, e.dest}) begin
          n_err++;
          $display("FAIL wb_entry: got we=%b cv=%b ex=%b rob=%h code=%h data=%h dest=%0d, required rob=%h excp=%b code=%h data=%h dest=%0d",
                   p2_we_o, completion_valid_o, exception_o, completed_rob_o, exception_code_o, p2_we_data_o,
                   p2_we_dest_o, e.rob, e.excp, e.code, e.data, e.dest);
        end
      end
    end
  end

  task automatic set_src(input int s, input logic [31:0] d, input logic [5:0] dst, input logic [5:0] rob,
                         input logic ex, input logic [3:0] code, input bit push);
    src_vld[s]            = 1'b1;
    src_data[s*32 +: 32]  = d;
    src_dest[s*6 +: 6]    = dst;
    src_rob[s*6 +: 6]     = rob;
    src_excp[s]           = ex;
    src_code[s*4 +: 4]    = code;
    if (push) sb.push_back('{d, dst, rob, ex, code});
  endtask

  task automatic test_reset;
    mon_en = 1'b0;
    @(posedge cpu_clk_i); #1;
    set_src(0, 32'hA0, 6'd1, 6'h01, 1'b0, 4'd0, 1'b0);
    set_src(1, 32'hA1, 6'd2, 6'h02, 1'b0, 4'd0, 1'b0);
    set_src(2, 32'hA2, 6'd3, 6'h03, 1'b0, 4'd0, 1'b0);
    repeat (3) @(posedge cpu_clk_i);
    #2;
    n_cmp++;
    if (completion_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre_traffic: got cv=%b, required 1", completion_valid_o);
    end
    cpu_rst_ni = 1'b0;
    src_vld    = 3'b000;
    #1;
    n_cmp++;
    if ({p2_we_o, completion_valid_o, exception_o, conflict_cnt_o, p2_we_data_o, completed_rob_o} !== '0) begin
      n_err++;
      $display("FAIL reset_async: got we=%b cv=%b ex=%b cnt=%0d data=%h rob=%h, required all 0",
               p2_we_o, completion_valid_o, exception_o, conflict_cnt_o, p2_we_data_o, completed_rob_o);
    end
    @(posedge cpu_clk_i); #1;
    cpu_rst_ni = 1'b1;
    @(negedge cpu_clk_i);
    n_cmp++;
    if (src_rdy !== 3'b111 || conflict_cnt_o !== 16'd0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b cnt=%0d, required rdy=111 cnt=0", src_rdy, conflict_cnt_o);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge cpu_clk_i);
      n_cmp++;
      if ({p2_we_o, completion_valid_o, exception_o} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_idle: got strobes=%b, required 000", {p2_we_o, completion_valid_o, exception_o});
      end
    end
    mon_en = 1'b1;
  endtask

  task automatic test_all_three;
    @(posedge cpu_clk_i); #1;
    set_src(0, 32'h1111_0000, 6'd10, 6'h20, 1'b0, 4'd0, 1'b1);
    set_src(1, 32'h2222_0000, 6'd11, 6'h21, 1'b0, 4'd0, 1'b1);
    set_src(2, 32'h3333_0000, 6'd12, 6'h22, 1'b0, 4'd0, 1'b1);
    @(posedge cpu_clk_i); #1;
    src_vld = 3'b000;
    for (int k = 1; k <= 5; k++) begin
      @(negedge cpu_clk_i);
      n_cmp++;
      if (completion_valid_o !== (k >= 2 && k <= 4)) begin
        n_err++;
        $display("FAIL all_three_timing: cycle N+%0d got cv=%b, required %b", k, completion_valid_o, k >= 2 && k <= 4);
      end
    end
    exp_conf += 2;
    n_cmp++;
    if (conflict_cnt_o !== exp_conf[15:0]) begin
      n_err++;
      $display("FAIL all_three_conflict: got %0d, required %0d", conflict_cnt_o, exp_conf);
    end
  endtask

  task automatic test_back_to_back;
    int strobes;
    strobes = 0;
    @(posedge cpu_clk_i); #1;
    for (int i = 0; i < 6; i++) begin
      set_src(2, 32'hC500_0000 + i, (i == 3) ? 6'd0 : 6'(20 + i), 6'(6'h30 + i), 1'b0, 4'd0, 1'b1);
      @(negedge cpu_clk_i);
      strobes += int'(completion_valid_o);
      n_cmp++;
      if (src_rdy[2] !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready: beat %0d got rdy2=%b, required 1", i, src_rdy[2]);
      end
      @(posedge cpu_clk_i); #1;
    end
    src_vld = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(negedge cpu_clk_i);
      strobes += int'(completion_valid_o);
    end
    n_cmp++;
    if (strobes !== 6) begin
      n_err++;
      $display("FAIL b2b_count: got %0d writebacks, required 6", strobes);
    end
  endtask

  task automatic test_exception;
    @(posedge cpu_clk_i); #1;
    set_src(2, 32'h0000_0BAD, 6'd5, 6'h13, 1'b1, 4'd2, 1'b1);
    @(posedge cpu_clk_i); #1;
    src_vld = 3'b000;
    @(posedge cpu_clk_i);
    @(negedge cpu_clk_i);
    n_cmp++;
    if ({exception_o, p2_we_o, completion_valid_o, exception_code_o, completed_rob_o} !== {3'b100, 4'd2, 6'h13}) begin
      n_err++;
      $display("FAIL exception: got ex=%b we=%b cv=%b code=%0d rob=%h, required ex=1 we=0 cv=0 code=2 rob=13",
               exception_o, p2_we_o, completion_valid_o, exception_code_o, completed_rob_o);
    end
  endtask

  task automatic test_single;
    @(posedge cpu_clk_i); #1;
    set_src(0, 32'hDEADBEEF, 6'd12, 6'h0A, 1'b0, 4'd0, 1'b1);
    for (int k = 0; k <= 3; k++) begin
      @(negedge cpu_clk_i);
      n_cmp++;
      if ({p2_we_o, completion_valid_o} !== {2{k == 2}}) begin
        n_err++;
        $display("FAIL single_latency: cycle N+%0d got we=%b cv=%b, required %b", k, p2_we_o, completion_valid_o, k == 2);
      end
      @(posedge cpu_clk_i); #1;
      src_vld = 3'b000;
    end
  endtask

  task automatic test_flush;
    @(posedge cpu_clk_i); #1;
    set_src(0, 32'hF0, 6'd7, 6'h2A, 1'b0, 4'd0, 1'b0);
    set_src(1, 32'hF1, 6'd8, 6'h2B, 1'b0, 4'd0, 1'b0);
    @(posedge cpu_clk_i); #1;
    src_vld = 3'b000;
    flush_i = 1'b1;
    set_src(1, 32'hF2, 6'd9, 6'h2C, 1'b0, 4'd0, 1'b0);
    @(negedge cpu_clk_i);
    n_cmp++;
    if (src_rdy !== 3'b000) begin
      n_err++;
      $display("FAIL flush_ready: got rdy=%b, required 000", src_rdy);
    end
    @(posedge cpu_clk_i); #1;
    flush_i = 1'b0;
    src_vld = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(negedge cpu_clk_i);
      n_cmp++;
      if ({p2_we_o, completion_valid_o, exception_o} !== 3'b000) begin
        n_err++;
        $display("FAIL flush_quiet: got strobes=%b, required 000", {p2_we_o, completion_valid_o, exception_o});
      end
    end
    n_cmp++;
    if (conflict_cnt_o !== exp_conf[15:0]) begin
      n_err++;
      $display("FAIL flush_conflict: got %0d, required %0d", conflict_cnt_o, exp_conf);
    end
    // pointer must restart at src0 after the flush
    @(posedge cpu_clk_i); #1;
    set_src(0, 32'h5000_0000, 6'd30, 6'h3A, 1'b0, 4'd0, 1'b1);
    set_src(1, 32'h5100_0000, 6'd31, 6'h3B, 1'b0, 4'd0, 1'b1);
    set_src(2, 32'h5200_0000, 6'd32, 6'h3C, 1'b0, 4'd0, 1'b1);
    @(posedge cpu_clk_i); #1;
    src_vld = 3'b000;
    repeat (6) @(negedge cpu_clk_i);
    exp_conf += 2;
    n_cmp++;
    if (conflict_cnt_o !== exp_conf[15:0]) begin
      n_err++;
      $display("FAIL post_flush_conflict: got %0d, required %0d", conflict_cnt_o, exp_conf);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; exp_conf = 0; mon_en = 1'b1;
    cpu_rst_ni = 1'b0; flush_i = 1'b0;
    src_vld = '0; src_excp = '0; src_data = '0; src_dest = '0; src_rob = '0; src_code = '0;
    repeat (2) @(posedge cpu_clk_i);
    #1 cpu_rst_ni = 1'b1;
    test_reset;
    test_all_three;
    test_back_to_back;
    test_exception;
    test_single;
    test_flush;
    repeat (2) @(negedge cpu_clk_i);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
